// File: rtl/psum_pkg.sv
// Shared definitions for the partial-sum accumulator: FSM encoding and the
// lane arithmetic helpers, computed at a fixed 64-bit working width.
package psum_pkg;

  typedef enum logic [2:0] {S_IDLE, S_FIRST, S_ACCUM, S_DRAIN, S_DONE} state_t;

  localparam int unsigned MAX_W = 64;

  // Sign-extend the low w bits of v to the full working width.
  function automatic logic signed [MAX_W-1:0] sext(input logic [MAX_W-1:0] v,
                                                   input int unsigned w);
    logic [MAX_W-1:0] hi_mask;
    logic             sgn;
    hi_mask = {MAX_W{1'b1}} << w;
    sgn     = |(v & (64'd1 << (w - 1)));
    return $signed(sgn ? (v | hi_mask) : (v & ~hi_mask));
  endfunction

  // Clamp v into the signed range of a w-bit value.
  function automatic logic signed [MAX_W-1:0] sat(input logic signed [MAX_W-1:0] v,
                                                  input int unsigned w);
    logic signed [MAX_W-1:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/psum_lane_add.sv
// One accumulator lane: acc + sign-extended psum, wrapping or saturating.
module psum_lane_add import psum_pkg::*; #(
  parameter int BIT_WIDTH = 8,
  parameter int ACC_WIDTH = 16
) (
  input  logic [ACC_WIDTH-1:0] acc,
  input  logic [BIT_WIDTH-1:0] psum,
  input  logic                 sat_en,
  output logic [ACC_WIDTH-1:0] sum
);

  logic signed [MAX_W-1:0] a_ext, p_ext, raw, res;
  logic                    unused_hi;

  always_comb begin
    a_ext = sext({{(MAX_W-ACC_WIDTH){1'b0}}, acc}, ACC_WIDTH);
    p_ext = sext({{(MAX_W-BIT_WIDTH){1'b0}}, psum}, BIT_WIDTH);
    raw   = a_ext + p_ext;
    res   = sat_en ? sat(raw, ACC_WIDTH) : raw;
  end

  // Wrap mode simply drops the carry bits above the lane width.
  assign sum       = res[ACC_WIDTH-1:0];
  assign unused_hi = ^res[MAX_W-1:ACC_WIDTH];

endmodule

// File: rtl/psum_accum_engine.sv
// Read-modify-write accumulator of psum vectors into external memory, with
// write forwarding for short passes and read-latency protocol checking.
module psum_accum_engine import psum_pkg::*; #(
  parameter int BIT_WIDTH  = 8,
  parameter int ACC_WIDTH  = 16,
  parameter int NUM_KERNEL = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_DELAY  = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_KERNEL*BIT_WIDTH-1:0]  psum_dat,
  input  logic                             psum_vld,
  output logic [ADDR_WIDTH-1:0]            mem_radd,
  output logic                             mem_rden,
  input  logic [NUM_KERNEL*ACC_WIDTH-1:0]  mem_odat,
  input  logic                             mem_ovld,
  output logic [ADDR_WIDTH-1:0]            mem_wadd,
  output logic                             mem_wren,
  output logic [NUM_KERNEL*ACC_WIDTH-1:0]  mem_idat,
  input  logic                             i_start,
  input  logic                             i_sat_en,
  input  logic [31:0]                      i_pass_len,
  input  logic [15:0]                      i_num_pass,
  output logic                             o_busy,
  output logic                             o_done,
  output logic                             o_err
);

  localparam int PW = NUM_KERNEL * BIT_WIDTH;
  localparam int AW = NUM_KERNEL * ACC_WIDTH;

  state_t                  state, state_nxt;
  logic [31:0]             pass_len, psum_cnt;
  logic [15:0]             num_pass, pass_cnt;
  logic                    sat_q;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic                    accept, start_fire, last_psum, last_pass;

  // Request pipeline: entry i belongs to the psum accepted i cycles ago.
  logic [MEM_DELAY:1]                 vld_pipe, rd_pipe;
  logic [MEM_DELAY:1][ADDR_WIDTH-1:0] addr_pipe;
  logic [MEM_DELAY:1][PW-1:0]         psum_pipe;

  // Writes issued in the last MEM_DELAY cycles; the output register is the youngest.
  logic [MEM_DELAY:1]                 wh_vld;
  logic [MEM_DELAY:1][ADDR_WIDTH-1:0] wh_addr;
  logic [MEM_DELAY:1][AW-1:0]         wh_dat;

  logic                                  d_vld, d_rd, rd_miss, rd_stray, fwd_hit;
  logic [ADDR_WIDTH-1:0]                 d_addr;
  logic [NUM_KERNEL-1:0][BIT_WIDTH-1:0]  d_psum;
  logic [AW-1:0]                         fwd_dat;
  logic [NUM_KERNEL-1:0][ACC_WIDTH-1:0]  base, sum_lanes;

  assign start_fire = i_start && (state == S_IDLE || state == S_DONE);
  assign accept     = psum_vld && (state == S_FIRST || state == S_ACCUM);
  assign last_psum  = (psum_cnt == pass_len - 32'd1);
  assign last_pass  = (pass_cnt == num_pass - 16'd1);
  assign mem_rden   = psum_vld && (state == S_ACCUM);
  assign mem_radd   = rd_addr;
  assign o_busy     = state inside {S_FIRST, S_ACCUM, S_DRAIN};
  assign o_done     = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (i_start) state_nxt = S_FIRST;
      S_FIRST:        if (accept && last_psum) state_nxt = last_pass ? S_DRAIN : S_ACCUM;
      S_ACCUM:        if (accept && last_psum && last_pass) state_nxt = S_DRAIN;
      S_DRAIN:        if (!(|vld_pipe)) state_nxt = S_DONE;
      default:        state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pass_len <= '0;
      num_pass <= '0;
      sat_q    <= 1'b0;
      rd_addr  <= '0;
      psum_cnt <= '0;
      pass_cnt <= '0;
    end else if (start_fire) begin
      pass_len <= i_pass_len;
      num_pass <= i_num_pass;
      sat_q    <= i_sat_en;
      rd_addr  <= '0;
      psum_cnt <= '0;
      pass_cnt <= '0;
    end else if (accept) begin
      if (last_psum) begin
        rd_addr  <= '0;
        psum_cnt <= '0;
        pass_cnt <= pass_cnt + 16'd1;
      end else begin
        rd_addr  <= rd_addr + ADDR_WIDTH'(1);
        psum_cnt <= psum_cnt + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_pipe  <= '0;
      rd_pipe   <= '0;
      addr_pipe <= '0;
      psum_pipe <= '0;
    end else begin
      vld_pipe[1]  <= accept;
      rd_pipe[1]   <= mem_rden;
      addr_pipe[1] <= rd_addr;
      psum_pipe[1] <= psum_dat;
      for (int i = 2; i <= MEM_DELAY; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        rd_pipe[i]   <= rd_pipe[i-1];
        addr_pipe[i] <= addr_pipe[i-1];
        psum_pipe[i] <= psum_pipe[i-1];
      end
    end
  end

  assign d_vld    = vld_pipe[MEM_DELAY];
  assign d_rd     = rd_pipe[MEM_DELAY];
  assign d_addr   = addr_pipe[MEM_DELAY];
  assign d_psum   = psum_pipe[MEM_DELAY];
  assign rd_miss  = d_vld && d_rd && !mem_ovld;
  assign rd_stray = mem_ovld && !(d_vld && d_rd);

  // Every write issued since this read was launched is invisible to memory
  // data; scan oldest to youngest so the youngest match wins.
  always_comb begin
    fwd_hit = 1'b0;
    fwd_dat = '0;
    for (int i = MEM_DELAY; i >= 1; i--) begin
      if (wh_vld[i] && wh_addr[i] == d_addr) begin
        fwd_hit = 1'b1;
        fwd_dat = wh_dat[i];
      end
    end
    if (mem_wren && mem_wadd == d_addr) begin
      fwd_hit = 1'b1;
      fwd_dat = mem_idat;
    end
    if (!d_rd || rd_miss) base = '0;
    else if (fwd_hit)     base = fwd_dat;
    else                  base = mem_odat;
  end

  for (genvar k = 0; k < NUM_KERNEL; k++) begin : g_lane
    psum_lane_add #(.BIT_WIDTH(BIT_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_add (
      .acc    (base[k]),
      .psum   (d_psum[k]),
      .sat_en (sat_q),
      .sum    (sum_lanes[k])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_wren <= 1'b0;
      mem_wadd <= '0;
      mem_idat <= '0;
      wh_vld   <= '0;
      wh_addr  <= '0;
      wh_dat   <= '0;
    end else begin
      mem_wren <= d_vld;
      if (d_vld) begin
        mem_wadd <= d_addr;
        mem_idat <= sum_lanes;
      end
      wh_vld[1]  <= mem_wren;
      wh_addr[1] <= mem_wadd;
      wh_dat[1]  <= mem_idat;
      for (int i = 2; i <= MEM_DELAY; i++) begin
        wh_vld[i]  <= wh_vld[i-1];
        wh_addr[i] <= wh_addr[i-1];
        wh_dat[i]  <= wh_dat[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)                     o_err <= 1'b0;
    else if (start_fire)          o_err <= 1'b0;
    else if (rd_miss || rd_stray) o_err <= 1'b1;
  end

endmodule

// File: doc/psum_accum_engine.md
PSUM_ACCUM_ENGINE -- requirements
Module: psum_accum_engine

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- BIT_WIDTH, 8: signed width of one incoming psum lane.
- ACC_WIDTH, 16: signed width of one accumulator lane in memory.
- NUM_KERNEL, 4: number of kernel lanes per memory word.
- ADDR_WIDTH, 32: memory address width.
- MEM_DELAY, 1: read latency in cycles from mem_rden to mem_ovld; legal range 1..4.
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk, in, 1: sole clock, rising edge.
- rst, in, 1: synchronous, active-low reset.
- psum_dat, in, NUM_KERNEL*BIT_WIDTH: psum lanes, lane k at bits [k*BIT_WIDTH +: BIT_WIDTH].
- psum_vld, in, 1: psum_dat valid; one psum per asserted cycle.
- mem_radd, out, ADDR_WIDTH: read address.
- mem_rden, out, 1: read strobe.
- mem_odat, in, NUM_KERNEL*ACC_WIDTH: read data.
- mem_ovld, in, 1: read data valid.
- mem_wadd, out, ADDR_WIDTH: write address.
- mem_wren, out, 1: write strobe.
- mem_idat, out, NUM_KERNEL*ACC_WIDTH: write data.
- i_start, in, 1: pulse that begins a job.
- i_sat_en, in, 1: 1 = saturating add, 0 = wrap-around add.
- i_pass_len, in, 32: psums per pass (P, at least 1).
- i_num_pass, in, 16: passes per job (N, at least 1).
- o_busy, out, 1: job in progress.
- o_done, out, 1: sticky job-complete flag.
- o_err, out, 1: sticky protocol-error flag.

Function
REQ-003 SHALL implement FSM IDLE, FIRST, ACCUM, DRAIN, DONE; o_busy = 1 in FIRST, ACCUM and DRAIN.
REQ-004 SHALL move IDLE/DONE -> FIRST on i_start, clearing rd_addr, psum count, pass count, o_done and o_err.
REQ-005 SHALL ignore i_start outside IDLE/DONE.
REQ-006 SHALL latch P, N and i_sat_en at i_start and hold them for the whole job.
REQ-007 In FIRST, SHALL write each psum (sign-extended to ACC_WIDTH) to rd_addr with no memory read (mem_rden = 0).
REQ-008 In ACCUM, SHALL assert mem_rden with mem_radd = rd_addr for each psum_vld.
REQ-009 SHALL write mem_odat + sign-extended psum to the same address exactly MEM_DELAY+1 cycles after the psum_vld cycle.
REQ-010 SHALL use the same MEM_DELAY+1 write latency in FIRST, so write order always equals accept order.
REQ-011 SHALL increment rd_addr per accepted psum and wrap it to 0 after P psums.
REQ-012 On that wrap, SHALL increment the pass count; FIRST -> ACCUM at the end of pass 0.
REQ-013 After pass N-1, SHALL enter DRAIN (including directly from FIRST when N = 1).
REQ-014 SHALL ignore psum_vld in IDLE, DRAIN and DONE.
REQ-015 In DRAIN, SHALL wait until the last write has issued, then enter DONE and set o_done.
REQ-016 Addition SHALL be per lane, ACC_WIDTH-bit signed.
REQ-017 With sat = 1, a lane result SHALL clamp to +2^(ACC_WIDTH-1)-1 or -2^(ACC_WIDTH-1).
REQ-018 With sat = 0, a lane result SHALL wrap modulo 2^ACC_WIDTH.
REQ-019 Read-after-write hazard: when P <= MEM_DELAY+1, an address can be read while its write is still in the pipeline. SHALL forward the youngest in-flight write data for that address in place of mem_odat, so every accumulation sees all earlier contributions.
REQ-020 SHALL set o_err when mem_ovld is not asserted exactly MEM_DELAY cycles after a mem_rden.
REQ-021 When REQ-020 fires, the affected write SHALL still issue, using 0 in place of mem_odat.
REQ-022 SHALL set o_err when mem_ovld is asserted with no matching mem_rden; that data is discarded.
REQ-023 o_err SHALL clear only on reset or i_start.
REQ-024 mem_wren SHALL be a registered output; mem_idat and mem_wadd SHALL be stable whenever mem_wren = 1.

Reset
REQ-025 On rst = 0 at a clock edge, SHALL enter IDLE and clear all counters, pipelines and forwarding state.
REQ-026 Outputs after reset SHALL be: mem_rden = 0, mem_wren = 0, mem_radd = 0, mem_wadd = 0, mem_idat = 0, o_busy = 0, o_done = 0, o_err = 0.
REQ-027 A reset mid-job SHALL abort in-flight writes: no mem_wren on the cycle after reset.

Structure
REQ-028 SHALL place the FSM state encoding and the lane sign-extend and saturate functions in a shared package, psum_pkg.
REQ-029 SHALL instantiate NUM_KERNEL copies of one sub-module, psum_lane_add (signed add with optional saturation, purely combinational).

Verification
REQ-030 Bench SHALL cover these directed scenarios:
- P=4, N=3, MEM_DELAY=1, lane0 psum=1 every cycle -> addresses 0..3 hold 3 in lane0; o_done rises after the last write.
- Saturation: sat=1, ACC_WIDTH=16, stored 32760, psum +127 -> 32767; with sat=0 -> -32649.
- Hazard: P=1, N=5, MEM_DELAY=2, psum=2 back-to-back -> address 0 holds 10.
- Negative lanes: psum lanes {-1,-2,-3,-4}, N=2 -> lanes {-2,-4,-6,-8}.
- Drop mem_ovld once in ACCUM -> o_err = 1, write issues with the psum value only; a new i_start clears o_err.
- rst = 0 during ACCUM -> next cycle mem_wren = 0 and o_busy = 0; a following job completes correctly.
